// File: rtl/laser_lane_transmitter.sv
// Multi-lane framed laser serialiser: start bit, data MSB-first, optional even parity, stop bit.
// All lanes share one bit-period timer; disabled lanes drive 2'b00 for the whole frame.
module laser_lane_transmitter #(
    parameter int LANES     = 2,
    parameter int DATA_W    = 8,
    parameter int DIV_W     = 8,
    parameter int PARITY_EN = 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      en,
    input  logic [DIV_W-1:0]          divider,
    input  logic [LANES-1:0]          lane_en,
    input  logic [LANES*DATA_W-1:0]   in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [2*LANES-1:0]        laser_out,
    output logic                      busy,
    output logic                      done
);

    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t             state_reg, state_next;
    logic [DIV_W-1:0]   cnt_reg, cnt_next;
    logic [DIV_W-1:0]   div_q_reg, div_q_next;
    logic [LANES-1:0]   en_q_reg, en_q_next;
    logic [BIT_W-1:0]   bit_reg, bit_next;
    logic               done_reg, done_next;
    logic               accept;
    logic               period_end;
    logic               shift_en;

    assign in_ready   = (state_reg == IDLE) && en && !reset;
    assign accept     = in_valid && in_ready;
    assign period_end = (cnt_reg == div_q_reg);
    assign busy       = (state_reg != IDLE);
    assign done       = done_reg;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        div_q_next = div_q_reg;
        en_q_next  = en_q_reg;
        bit_next   = bit_reg;
        done_next  = 1'b0;
        shift_en   = 1'b0;

        // Counter runs 0..div_q inclusive, so divider at full scale never wraps early.
        if (state_reg != IDLE) begin
            cnt_next = period_end ? '0 : cnt_reg + 1'b1;
        end

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = START;
                    cnt_next   = '0;
                    div_q_next = divider;
                    en_q_next  = lane_en;
                end
            end
            START: begin
                if (period_end) begin
                    state_next = DATA;
                    bit_next   = BIT_W'(DATA_W - 1);
                end
            end
            DATA: begin
                if (period_end) begin
                    shift_en = 1'b1;
                    if (bit_reg == '0) begin
                        state_next = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_next = bit_reg - 1'b1;
                    end
                end
            end
            PARITY: begin
                if (period_end) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (period_end) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            div_q_reg <= '0;
            en_q_reg  <= '0;
            bit_reg   <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            div_q_reg <= div_q_next;
            en_q_reg  <= en_q_next;
            bit_reg   <= bit_next;
            done_reg  <= done_next;
        end
    end

    // Each lane registers its pin pair from next-state values so the pins change on the same
    // edge as the state register, with no combinational path to the optics.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [DATA_W-1:0] word_in;
            logic [DATA_W-1:0] shift_reg, shift_next;
            logic              par_reg, par_next;
            logic              lane_on_next;
            logic              line_bit;
            logic [1:0]        pair_reg;

            assign word_in = in_data[gi*DATA_W +: DATA_W];

            always_comb begin
                shift_next   = shift_reg;
                par_next     = par_reg;
                lane_on_next = en_q_next[gi];
                line_bit     = 1'b0;
                if (accept) begin
                    shift_next = word_in;
                    par_next   = ^word_in;
                end else if (shift_en) begin
                    shift_next = shift_reg << 1;
                end
                case (state_next)
                    START:   line_bit = 1'b1;
                    DATA:    line_bit = shift_next[DATA_W-1];
                    PARITY:  line_bit = par_next;
                    default: line_bit = 1'b0;
                endcase
            end

            always_ff @(posedge clock) begin
                if (reset) begin
                    shift_reg <= '0;
                    par_reg   <= 1'b0;
                    pair_reg  <= 2'b00;
                end else begin
                    shift_reg <= shift_next;
                    par_reg   <= par_next;
                    pair_reg  <= (lane_on_next && state_next != IDLE) ? {line_bit, ~line_bit} : 2'b00;
                end
            end

            assign laser_out[2*gi +: 2] = pair_reg;
        end
    endgenerate

endmodule
